key_scan_ps2: RTL and testbench

KEY_SCAN_PS2 -- requirements
Module: key_scan_ps2

---
 rtl/key_scan_ps2_pkg.sv | 43 ++++
 rtl/key_scan_ps2_rx.sv | 118 +++++++++++
 rtl/key_scan_ps2.sv | 86 ++++++++
 tb/tb_key_scan_ps2.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/key_scan_ps2_pkg.sv
// Shared PS/2 key-scan definitions: RAM address, special scan codes,
// receiver state encoding and the set-2 scan-code to ASCII table.
package key_scan_ps2_pkg;

    localparam logic [12:0] SCAN_ASCII_ADDR = 13'h0310;

    localparam logic [7:0] CODE_BRK    = 8'hF0;
    localparam logic [7:0] CODE_EXT    = 8'hE0;
    localparam logic [7:0] CODE_LSHIFT = 8'h12;
    localparam logic [7:0] CODE_RSHIFT = 8'h59;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } rx_state_t;

    // Returns 0 for codes with no printable mapping; letters shift to upper case.
    function automatic logic [7:0] scan_to_ascii(input logic [7:0] code, input logic shift);
        logic [7:0] r;
        r = '0;
        case (code)
            8'h1C: r = 8'h61;  8'h32: r = 8'h62;  8'h21: r = 8'h63;  8'h23: r = 8'h64;
            8'h24: r = 8'h65;  8'h2B: r = 8'h66;  8'h34: r = 8'h67;  8'h33: r = 8'h68;
            8'h43: r = 8'h69;  8'h3B: r = 8'h6A;  8'h42: r = 8'h6B;  8'h4B: r = 8'h6C;
            8'h3A: r = 8'h6D;  8'h31: r = 8'h6E;  8'h44: r = 8'h6F;  8'h4D: r = 8'h70;
            8'h15: r = 8'h71;  8'h2D: r = 8'h72;  8'h1B: r = 8'h73;  8'h2C: r = 8'h74;
            8'h3C: r = 8'h75;  8'h2A: r = 8'h76;  8'h1D: r = 8'h77;  8'h22: r = 8'h78;
            8'h35: r = 8'h79;  8'h1A: r = 8'h7A;
            8'h45: r = 8'h30;  8'h16: r = 8'h31;  8'h1E: r = 8'h32;  8'h26: r = 8'h33;
            8'h25: r = 8'h34;  8'h2E: r = 8'h35;  8'h36: r = 8'h36;  8'h3D: r = 8'h37;
            8'h3E: r = 8'h38;  8'h46: r = 8'h39;
            8'h29: r = 8'h20;  8'h5A: r = 8'h0D;  8'h66: r = 8'h08;
            default: r = '0;
        endcase
        if (shift && r >= 8'h61 && r <= 8'h7A) begin
            r = r - 8'h20;
        end
        return r;
    endfunction

endpackage

// File: rtl/key_scan_ps2_rx.sv
// PS/2 frame receiver: line synchronizers, start/data/parity/stop FSM and
// inter-edge timeout; emits a one-cycle code_valid with each good byte.
module ps2_rx
    import key_scan_ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 5000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic       o_code_valid,
    output logic [7:0] o_code
);

    localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

    logic            r_clk_s1, r_clk_s2, r_clk_s3;
    logic            r_dat_s1, r_dat_s2;
    rx_state_t       r_state, w_state_nxt;
    logic [2:0]      r_bit_cnt;
    logic [7:0]      r_shift;
    logic            r_parity;
    logic [TW-1:0]   r_to_cnt;
    logic            r_code_valid;
    logic [7:0]      r_code;
    logic            w_fall;
    logic            w_timeout;
    logic            w_frame_ok;

    assign w_fall    = r_clk_s3 & ~r_clk_s2;
    // An edge clears the counter, so it takes priority over an expiring timeout.
    assign w_timeout = (r_state != ST_IDLE) && !w_fall && (r_to_cnt == TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_clk_s3 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
        end else begin
            r_clk_s1 <= i_ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_clk_s3 <= r_clk_s2;
            r_dat_s1 <= i_ps2_data;
            r_dat_s2 <= r_dat_s1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_frame_ok  = 1'b0;
        if (w_timeout) begin
            w_state_nxt = ST_IDLE;
        end else if (w_fall) begin
            case (r_state)
                ST_IDLE:   if (!r_dat_s2) w_state_nxt = ST_DATA;
                ST_DATA:   if (r_bit_cnt == 3'd7) w_state_nxt = ST_PARITY;
                ST_PARITY: w_state_nxt = ST_STOP;
                ST_STOP: begin
                    w_state_nxt = ST_IDLE;
                    w_frame_ok  = r_dat_s2 && (^{r_shift, r_parity});
                end
                default:   w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_parity     <= 1'b0;
            r_code_valid <= 1'b0;
            r_code       <= '0;
        end else begin
            r_code_valid <= w_frame_ok;
            if (w_frame_ok) begin
                r_code <= r_shift;
            end
            if (w_fall && !w_timeout) begin
                case (r_state)
                    ST_IDLE:   r_bit_cnt <= '0;
                    ST_DATA: begin
                        r_shift   <= {r_dat_s2, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                    end
                    ST_PARITY: r_parity <= r_dat_s2;
                    default:   ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt <= '0;
        end else if (w_fall || w_timeout || r_state == ST_IDLE) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    assign o_code_valid = r_code_valid;
    assign o_code       = r_code;

endmodule

// File: rtl/key_scan_ps2.sv
// PS/2 keyboard scanner: decodes make/break/extended scan codes into the ASCII
// of the currently held key, presented at a fixed RAM address.
module key_scan_ps2
    import key_scan_ps2_pkg::*;
#(
    parameter logic [12:0] SCAN_ADDR   = SCAN_ASCII_ADDR,
    parameter int unsigned TIMEOUT_CYC = 5000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [12:0] key_ram_addr,
    output logic [31:0] key_ram_wdata,
    output logic        key_ram_wen
);

    logic       w_code_valid;
    logic [7:0] w_code;
    logic [7:0] w_ascii;
    logic       w_is_shift;

    logic       r_brk;
    logic       r_ext;
    logic       r_shift_key;
    logic [7:0] r_held;
    logic [7:0] r_wdata;
    logic       r_wen;

    ps2_rx #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_rx (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_ps2_clk    (ps2_clk),
        .i_ps2_data   (ps2_data),
        .o_code_valid (w_code_valid),
        .o_code       (w_code)
    );

    assign w_ascii    = scan_to_ascii(w_code, r_shift_key);
    assign w_is_shift = (w_code == CODE_LSHIFT) || (w_code == CODE_RSHIFT);

    // Prefix codes only arm flags; the following code consumes and clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_brk       <= 1'b0;
            r_ext       <= 1'b0;
            r_shift_key <= 1'b0;
            r_held      <= '0;
            r_wdata     <= '0;
            r_wen       <= 1'b0;
        end else if (w_code_valid) begin
            if (w_code == CODE_BRK) begin
                r_brk <= 1'b1;
            end else if (w_code == CODE_EXT) begin
                r_ext <= 1'b1;
            end else begin
                r_brk <= 1'b0;
                r_ext <= 1'b0;
                if (!r_ext) begin
                    if (!r_brk) begin
                        if (w_is_shift) begin
                            r_shift_key <= 1'b1;
                        end else if (w_ascii != '0) begin
                            r_wdata <= w_ascii;
                            r_wen   <= 1'b1;
                            r_held  <= w_code;
                        end
                    end else begin
                        if (w_is_shift) begin
                            r_shift_key <= 1'b0;
                        end else if (w_code == r_held) begin
                            r_wen <= 1'b0;
                        end
                    end
                end
            end
        end
    end

    assign key_ram_addr  = SCAN_ADDR;
    assign key_ram_wdata = {24'h0, r_wdata};
    assign key_ram_wen   = r_wen;

endmodule

// File: tb/tb_key_scan_ps2.sv
// Scoreboard bench for key_scan_ps2: a PS/2 device driver pushes expected
// outputs per frame, a monitor checks them around the stop-bit edge.
module tb_key_scan_ps2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [12:0] key_ram_addr;
    logic [31:0] key_ram_wdata;
    logic        key_ram_wen;

    key_scan_ps2 #(
        .SCAN_ADDR   (13'h0310),
        .TIMEOUT_CYC (5000)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ps2_clk       (ps2_clk),
        .ps2_data      (ps2_data),
        .key_ram_addr  (key_ram_addr),
        .key_ram_wdata (key_ram_wdata),
        .key_ram_wen   (key_ram_wen)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int half = 8;

    typedef struct {
        logic        wen_pre;
        logic [31:0] wd_pre;
        logic        wen;
        logic [31:0] wd;
    } exp_t;

    exp_t q[$];
    event stop_ev;

    bit       m_brk, m_ext, m_shift, m_wen;
    bit [7:0] m_wdata, m_held;

    logic [7:0] pool [0:47] = '{
        8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
        8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
        8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A, 8'h45, 8'h16, 8'h1E, 8'h46,
        8'h29, 8'h5A, 8'h66, 8'h12, 8'h59, 8'h12, 8'hF0, 8'hF0, 8'hF0, 8'hF0,
        8'hE0, 8'h76, 8'h0E, 8'h05, 8'h1C, 8'h1C, 8'h32, 8'h59
    };

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
        end
    endtask

    // Key legend of scan code set 2, read straight off a keyboard chart.
    function automatic bit [7:0] lookup(input bit [7:0] code, input bit sh);
        string    letters = "abcdefghijklmnopqrstuvwxyz";
        string    upper   = letters.toupper();
        string    digits  = "0123456789";
        bit [7:0] lc [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                              8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                              8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
        bit [7:0] dc [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
        for (int i = 0; i < 26; i++) if (lc[i] == code) return sh ? upper[i] : letters[i];
        for (int i = 0; i < 10; i++) if (dc[i] == code) return digits[i];
        if (code == 8'h29) return " ";
        if (code == 8'h5A) return 8'h0D;
        if (code == 8'h66) return 8'h08;
        return 8'h00;
    endfunction

    task automatic model_reset();
        m_brk = 0; m_ext = 0; m_shift = 0; m_wen = 0; m_wdata = 0; m_held = 0;
    endtask

    task automatic model_apply(input bit [7:0] code);
        bit [7:0] ch;
        bit       is_shift;
        is_shift = (code == 8'h12) || (code == 8'h59);
        if (code == 8'hF0) m_brk = 1;
        else if (code == 8'hE0) m_ext = 1;
        else begin
            if (!m_ext && !m_brk) begin
                ch = lookup(code, m_shift);
                if (is_shift) m_shift = 1;
                else if (ch != 0) begin m_wdata = ch; m_wen = 1; m_held = code; end
            end else if (!m_ext && m_brk) begin
                if (is_shift) m_shift = 0;
                else if (code == m_held) m_wen = 0;
            end
            m_brk = 0;
            m_ext = 0;
        end
    endtask

    function automatic logic [10:0] frame_bits(input logic [7:0] code, input bit bad_par, input bit bad_stop);
        logic [10:0] b;
        b[0]   = 1'b0;
        b[8:1] = code;
        b[9]   = (~^code) ^ bad_par;
        b[10]  = ~bad_stop;
        return b;
    endfunction

    task automatic drive_bit(input logic b, input bit is_stop, input bit good, input logic [7:0] code);
        exp_t e;
        @(negedge clk);
        ps2_data = b;
        repeat (half) @(negedge clk);
        ps2_clk = 1'b0;
        if (is_stop) begin
            e.wen_pre = m_wen;
            e.wd_pre  = {24'h0, m_wdata};
            if (good) model_apply(code);
            e.wen = m_wen;
            e.wd  = {24'h0, m_wdata};
            q.push_back(e);
            -> stop_ev;
        end
        repeat (half) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] code, input bit bad_par, input bit bad_stop);
        logic [10:0] b;
        b = frame_bits(code, bad_par, bad_stop);
        for (int i = 0; i < 11; i++) drive_bit(b[i], i == 10, !bad_par && !bad_stop, code);
    endtask

    task automatic send_partial(input logic [7:0] code, input int from, input int to);
        logic [10:0] b;
        b = frame_bits(code, 1'b0, 1'b0);
        for (int i = from; i <= to; i++) drive_bit(b[i], 1'b0, 1'b0, code);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // Outputs must hold until the 4th rising clk after the bench drops ps2_clk.
    initial begin : monitor
        exp_t e;
        forever begin
            @(stop_ev);
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scoreboard_empty actual=0 required=1");
            end else begin
                e = q.pop_front();
                repeat (3) @(negedge clk);
                check("wen_before", {31'h0, key_ram_wen}, {31'h0, e.wen_pre});
                check("wdata_before", key_ram_wdata, e.wd_pre);
                @(negedge clk);
                check("wen_after", {31'h0, key_ram_wen}, {31'h0, e.wen});
                check("wdata_after", key_ram_wdata, e.wd);
                check("addr", {19'h0, key_ram_addr}, 32'h0000_0310);
            end
        end
    end

    initial begin : watchdog
        #900_000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_wen", {31'h0, key_ram_wen}, 32'h0);
        check("reset_wdata", key_ram_wdata, 32'h0);
        check("reset_addr", {19'h0, key_ram_addr}, 32'h0000_0310);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        send_frame(8'h1C, 0, 0);
        send_frame(8'hF0, 0, 0);
        send_frame(8'h1C, 0, 0);
        send_frame(8'h1C, 0, 0);
        send_frame(8'h1C, 0, 0);
        send_frame(8'hF0, 0, 0);
        send_frame(8'h1C, 0, 0);
        send_frame(8'h12, 0, 0);
        send_frame(8'h1C, 0, 0);
        send_frame(8'h32, 0, 0);
        send_frame(8'hF0, 0, 0);
        send_frame(8'h12, 0, 0);
        send_frame(8'h1C, 0, 0);
        send_frame(8'hE0, 0, 0);
        send_frame(8'h32, 0, 0);

        do_reset();
        send_frame(8'h1C, 1, 0);
        send_frame(8'h1C, 0, 1);

        send_partial(8'h5A, 0, 3);
        repeat (5000) @(negedge clk);
        send_frame(8'h5A, 0, 0);

        send_partial(8'h1C, 0, 4);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_reset_wen", {31'h0, key_ram_wen}, 32'h0);
        check("async_reset_wdata", key_ram_wdata, 32'h0);
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        send_partial(8'h1C, 5, 10);
        repeat (5100) @(negedge clk);
        send_frame(8'h29, 0, 0);

        for (int n = 0; n < 70; n++) begin
            half = $urandom_range(6, 12);
            send_frame(pool[$urandom_range(0, 47)], $urandom_range(0, 9) == 0, $urandom_range(0, 14) == 0);
        end

        repeat (20) @(negedge clk);
        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_leftover actual=%0d required=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
